// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: bus bundle between the fetch stage, instruction memory, hazard/branch logic and decode
//   master (fetch stage): drives imem_req/imem_addr and the IF/ID outputs if_valid/if_instr/if_pc,
//                         receives imem_ack/imem_rdata, stall, br_taken/br_target
//   slave (environment):  the mirror image
interface if_fetch_stage_if #(
  parameter int ADDR_W  = 64,
  parameter int INSTR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               stall;
  logic               br_taken;
  logic [ADDR_W-1:0]  br_target;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc,
    input  imem_ack, imem_rdata, stall, br_taken, br_target
  );
  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc,
    output imem_ack, imem_rdata, stall, br_taken, br_target
  );
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: LEGv8 instruction fetch with IF/ID register, one-outstanding imem handshake, stall skid and branch squash
//   clk   : rising-edge clock
//   reset : asynchronous active-low reset
//   bus   : if_fetch_stage_if.master (imem req/addr/ack/rdata, stall, br_taken/br_target, if_valid/if_instr/if_pc)
module if_fetch_stage #(
  parameter int                ADDR_W   = 64,
  parameter int                INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic              clk,
  input logic              reset,
  if_fetch_stage_if.master bus
);
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2, DISCARD = 2'd3;
  logic [1:0]         state;
  logic [ADDR_W-1:0]  pc, old_addr, skid_pc, id_pc;
  logic [INSTR_W-1:0] skid_instr, id_instr;
  logic               id_valid;
  assign bus.imem_req  = state == FETCH || state == DISCARD;
  // a squashed request must stay on its original address until memory acks it
  assign bus.imem_addr = state == DISCARD ? old_addr : pc;
  assign bus.if_valid  = id_valid;
  assign bus.if_instr  = id_instr;
  assign bus.if_pc     = id_pc;
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      old_addr   <= '0;
      skid_pc    <= '0;
      skid_instr <= '0;
      id_valid   <= 1'b0;
      id_instr   <= '0;
      id_pc      <= '0;
    end else begin
      case (state)
        IDLE: state <= FETCH;
        FETCH: begin
          if (bus.br_taken) begin
            id_valid <= 1'b0;
            pc       <= bus.br_target;
            if (!bus.imem_ack) begin
              old_addr <= pc;
              state    <= DISCARD;
            end
          end else if (bus.imem_ack) begin
            pc <= pc + ADDR_W'(4);
            if (bus.stall) begin
              skid_instr <= bus.imem_rdata;
              skid_pc    <= pc;
              state      <= HOLD;
            end else begin
              id_valid <= 1'b1;
              id_instr <= bus.imem_rdata;
              id_pc    <= pc;
            end
          end else if (!bus.stall) begin
            id_valid <= 1'b0;
          end
        end
        HOLD: begin
          if (bus.br_taken) begin
            id_valid <= 1'b0;
            pc       <= bus.br_target;
            state    <= FETCH;
          end else if (!bus.stall) begin
            id_valid <= 1'b1;
            id_instr <= skid_instr;
            id_pc    <= skid_pc;
            state    <= FETCH;
          end
        end
        default: begin
          id_valid <= 1'b0;
          if (bus.br_taken) pc <= bus.br_target;
          else if (bus.imem_ack) state <= FETCH;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed scenarios plus random stall/branch/ack/reset traffic against a queue-based fetch model
module tb_if_fetch_stage;
  logic clk = 1'b0;
  logic reset = 1'b0;
  int errors = 0;
  int checks = 0;
  always #5 clk = ~clk;
  if_fetch_stage_if bus ();
  if_fetch_stage dut (.clk(clk), .reset(reset), .bus(bus));
  bit          m_run;
  logic [63:0] m_pc;
  logic [95:0] skid_q[$];
  logic [63:0] drop_q[$];
  logic        m_valid;
  logic [31:0] m_instr;
  logic [63:0] m_ifpc;
  logic        exp_req;
  logic [63:0] exp_addr;
  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", n, a, e, $time);
    end
  endtask
  // reference: fetch address stream, parked instruction queue and owed-ack queue
  always @(negedge clk) begin
    if (!reset) begin
      m_run = 0;
      m_pc = 64'd0;
      skid_q.delete();
      drop_q.delete();
      m_valid = 1'b0;
      m_instr = '0;
      m_ifpc = '0;
      chk("m_rst_req", 64'(bus.imem_req), 64'd0);
      chk("m_rst_valid", 64'(bus.if_valid), 64'd0);
    end else begin
      exp_req = m_run && skid_q.size() == 0;
      exp_addr = drop_q.size() != 0 ? drop_q[0] : m_pc;
      chk("m_req", 64'(bus.imem_req), 64'(exp_req));
      chk("m_addr", bus.imem_addr, exp_addr);
      chk("m_valid", 64'(bus.if_valid), 64'(m_valid));
      if (m_valid) begin
        chk("m_instr", 64'(bus.if_instr), 64'(m_instr));
        chk("m_pc", bus.if_pc, m_ifpc);
      end
      if (!m_run) m_run = 1;
      else if (bus.br_taken) begin
        if (exp_req && drop_q.size() == 0 && !bus.imem_ack) drop_q.push_back(m_pc);
        skid_q.delete();
        m_valid = 1'b0;
        m_pc = bus.br_target;
      end else if (drop_q.size() != 0) begin
        m_valid = 1'b0;
        if (bus.imem_ack) drop_q.delete();
      end else if (skid_q.size() != 0) begin
        if (!bus.stall) begin
          {m_instr, m_ifpc} = skid_q.pop_front();
          m_valid = 1'b1;
        end
      end else if (bus.imem_ack) begin
        if (bus.stall) skid_q.push_back({bus.imem_rdata, m_pc});
        else begin
          m_valid = 1'b1;
          m_instr = bus.imem_rdata;
          m_ifpc = m_pc;
        end
        m_pc = m_pc + 64'd4;
      end else if (!bus.stall) m_valid = 1'b0;
    end
  end
  task automatic step(input bit s, input bit b, input logic [63:0] t, input bit a);
    @(posedge clk);
    #1;
    bus.stall = s;
    bus.br_taken = b;
    bus.br_target = t;
    bus.imem_ack = a && bus.imem_req;
    bus.imem_rdata = bus.imem_ack ? bus.imem_addr[31:0] + 32'hA000 : $urandom;
  endtask
  task automatic see(input string n, input bit r, input logic [63:0] ad, input bit v, input logic [63:0] p);
    chk({n, "_req"}, 64'(bus.imem_req), 64'(r));
    chk({n, "_addr"}, bus.imem_addr, ad);
    chk({n, "_valid"}, 64'(bus.if_valid), 64'(v));
    if (v) begin
      chk({n, "_pc"}, bus.if_pc, p);
      chk({n, "_instr"}, 64'(bus.if_instr), 64'(p[31:0] + 32'hA000));
    end
  endtask
  task automatic do_reset(input int n);
    #2 reset = 1'b0;
    #1;
    chk("arst_req", 64'(bus.imem_req), 64'd0);
    chk("arst_valid", 64'(bus.if_valid), 64'd0);
    chk("arst_addr", bus.imem_addr, 64'd0);
    repeat (n) @(posedge clk);
    #1;
    reset = 1'b1;
    bus.imem_ack = 1'b0;
    bus.stall = 1'b0;
    bus.br_taken = 1'b0;
  endtask
  initial begin
    bus.stall = 1'b0;
    bus.br_taken = 1'b0;
    bus.br_target = '0;
    bus.imem_ack = 1'b0;
    bus.imem_rdata = '0;
    repeat (3) @(negedge clk);
    see("reset", 1'b0, 64'h0, 1'b0, 64'h0);
    chk("reset_instr", 64'(bus.if_instr), 64'd0);
    chk("reset_pc", bus.if_pc, 64'd0);
    @(posedge clk);
    #1 reset = 1'b1;
    step(0, 0, 0, 1); see("t1_a", 1, 64'h0, 0, 0);
    step(0, 0, 0, 1); see("t1_b", 1, 64'h4, 1, 64'h0);
    step(1, 0, 0, 1); see("t2_c", 1, 64'h8, 1, 64'h4);
    step(1, 0, 0, 1); see("t2_d", 0, 64'hC, 1, 64'h4);
    step(1, 0, 0, 1); see("t2_e", 0, 64'hC, 1, 64'h4);
    step(0, 0, 0, 1); see("t2_f", 0, 64'hC, 1, 64'h4);
    step(0, 0, 0, 1); see("t2_g", 1, 64'hC, 1, 64'h8);
    step(0, 1, 64'h100, 0); see("t3_h", 1, 64'h10, 1, 64'hC);
    step(0, 0, 0, 0); see("t3_i", 1, 64'h10, 0, 0);
    step(0, 0, 0, 0); see("t3_j", 1, 64'h10, 0, 0);
    step(0, 0, 0, 1); see("t3_k", 1, 64'h10, 0, 0);
    step(0, 0, 0, 1); see("t3_l", 1, 64'h100, 0, 0);
    step(0, 1, 64'h20, 1); see("t3_m", 1, 64'h104, 1, 64'h100);
    step(0, 1, 64'h200, 1); see("t4_n", 1, 64'h20, 0, 0);
    step(0, 0, 0, 1); see("t4_o", 1, 64'h200, 0, 0);
    step(0, 1, 64'h30, 1); see("t4_p", 1, 64'h204, 1, 64'h200);
    step(1, 0, 0, 1); see("t5_q", 1, 64'h30, 0, 0);
    step(1, 1, 64'h80, 1); see("t5_r", 0, 64'h34, 0, 0);
    step(0, 0, 0, 1); see("t5_s", 1, 64'h80, 0, 0);
    step(0, 1, 64'h300, 0); see("t6_t", 1, 64'h84, 1, 64'h80);
    step(0, 1, 64'h400, 0); see("t6_u", 1, 64'h84, 0, 0);
    step(0, 0, 0, 0); see("t6_v", 1, 64'h84, 0, 0);
    do_reset(2);
    step(0, 0, 0, 1); see("t6_w", 1, 64'h0, 0, 0);
    step(0, 0, 0, 1); see("t6_x", 1, 64'h4, 1, 64'h0);
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 9) < 3, $urandom_range(0, 15) == 0,
           $urandom_range(0, 5) == 0 ? 64'hFFFF_FFFF_FFFF_FFF4 : {$urandom, $urandom},
           $urandom_range(0, 9) < 6);
      if ($urandom_range(0, 499) == 0) do_reset(2);
    end
    step(0, 0, 0, 0);
    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
